// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the fpu_ss integer writeback path.
package fpu_ss_pkg;

  localparam int unsigned CSR_WB_DEPTH_DEFAULT = 2;
  // Storage width for ids; instances use the low ID_WIDTH bits.
  localparam int unsigned IntWbIdMaxWidth = 8;

  typedef struct packed {
    logic [IntWbIdMaxWidth-1:0] id;
    logic [4:0]                 rd;
    logic [31:0]                data;
    logic                       we;
  } int_wb_entry_t;

  typedef enum logic {
    GrantFpu = 1'b0,
    GrantCsr = 1'b1
  } grant_e;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Small FIFO for writeback entries; push and pop in the same cycle are legal when full.
module fpu_ss_wb_fifo #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  entry_t          data_i,
  input  logic            pop_i,
  output entry_t          data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  entry_t          r_mem [Depth];
  logic            w_push, w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign w_pop   = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = push_i & (~full_o | w_pop);
  assign data_o  = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/fpu_ss_int_wb.sv
// Buffers CSR writeback pulses and arbitrates them against FPU integer results
// onto a registered valid/ready result channel towards the core.
module fpu_ss_int_wb
  import fpu_ss_pkg::*;
#(
  parameter int unsigned CSR_DEPTH = CSR_WB_DEPTH_DEFAULT,
  parameter int unsigned ID_WIDTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                csr_wb_i,
  input  logic [4:0]          csr_wb_addr_i,
  input  logic [ID_WIDTH-1:0] csr_wb_id_i,
  input  logic [31:0]         csr_rdata_i,
  output logic                csr_stall_o,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic [4:0]          fpu_rd_i,
  input  logic [ID_WIDTH-1:0] fpu_id_i,
  input  logic [31:0]         fpu_data_i,
  input  logic                fpu_we_i,
  output logic                x_result_valid_o,
  input  logic                x_result_ready_i,
  output logic [ID_WIDTH-1:0] x_result_id_o,
  output logic [4:0]          x_result_rd_o,
  output logic [31:0]         x_result_data_o,
  output logic                x_result_we_o,
  output logic                overflow_o
);

  localparam int unsigned CntW = $clog2(CSR_DEPTH + 1);

  int_wb_entry_t   w_csr_entry, w_fpu_entry, w_head;
  logic            w_full, w_empty;
  logic [CntW-1:0] w_count;
  logic            w_can_load, w_csr_req, w_csr_pref, w_csr_grant, w_fpu_grant, w_fpu_ready;

  logic            r_valid;
  int_wb_entry_t   r_out;
  grant_e          r_last_grant;
  logic            r_overflow;

  // Build the entries offered by both sources.
  always_comb begin
    w_csr_entry      = '0;
    w_csr_entry.id   = IntWbIdMaxWidth'(csr_wb_id_i);
    w_csr_entry.rd   = csr_wb_addr_i;
    w_csr_entry.data = csr_rdata_i;
    w_csr_entry.we   = (csr_wb_addr_i != 5'd0);
    w_fpu_entry      = '0;
    w_fpu_entry.id   = IntWbIdMaxWidth'(fpu_id_i);
    w_fpu_entry.rd   = fpu_rd_i;
    w_fpu_entry.data = fpu_data_i;
    w_fpu_entry.we   = fpu_we_i;
  end

  fpu_ss_wb_fifo #(
    .Depth   (CSR_DEPTH),
    .entry_t (int_wb_entry_t)
  ) u_csr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (csr_wb_i),
    .data_i  (w_csr_entry),
    .pop_i   (w_csr_grant),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Round-robin arbitration; a full FIFO takes priority since CSR pulses cannot stall.
  always_comb begin
    w_can_load  = ~r_valid | x_result_ready_i;
    w_csr_req   = ~w_empty;
    w_csr_pref  = w_full | (r_last_grant == GrantFpu);
    w_csr_grant = w_can_load & w_csr_req & (~fpu_valid_i | w_csr_pref);
    // Independent of fpu_valid_i: FPU is ready whenever CSR would not win a tie.
    w_fpu_ready = w_can_load & (~w_csr_req | ~w_csr_pref);
    w_fpu_grant = w_fpu_ready & fpu_valid_i;
  end

  // Output register, grant history and sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_out        <= '0;
      r_last_grant <= GrantFpu;
      r_overflow   <= 1'b0;
    end else begin
      if (w_can_load) begin
        r_valid <= w_csr_grant | w_fpu_grant;
        if (w_csr_grant) begin
          r_out        <= w_head;
          r_last_grant <= GrantCsr;
        end else if (w_fpu_grant) begin
          r_out        <= w_fpu_entry;
          r_last_grant <= GrantFpu;
        end
      end
      if (csr_wb_i && w_full && !w_csr_grant) r_overflow <= 1'b1;
    end
  end

  // The count is registered, so the stall leaves room for the pulse already in flight.
  assign csr_stall_o      = (w_count >= CntW'(CSR_DEPTH - 1));
  assign fpu_ready_o      = w_fpu_ready & ~rst_i;
  assign x_result_valid_o = r_valid;
  assign x_result_id_o    = r_out.id[ID_WIDTH-1:0];
  assign x_result_rd_o    = r_out.rd;
  assign x_result_data_o  = r_out.data;
  assign x_result_we_o    = r_out.we;
  assign overflow_o       = r_overflow;

  if (ID_WIDTH < IntWbIdMaxWidth) begin : g_id_unused
    logic w_unused_id;
    assign w_unused_id = ^r_out.id[IntWbIdMaxWidth-1:ID_WIDTH];
  end

endmodule

// File: tb/tb_fpu_ss_int_wb.sv
// Randomised and directed bench for fpu_ss_int_wb against a queue-based reference model.
module tb_fpu_ss_int_wb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        csr_wb_i = 1'b0;
  logic [4:0]  csr_wb_addr_i = '0;
  logic [3:0]  csr_wb_id_i = '0;
  logic [31:0] csr_rdata_i = '0;
  logic        csr_stall_o;
  logic        fpu_valid_i = 1'b0;
  logic        fpu_ready_o;
  logic [4:0]  fpu_rd_i = '0;
  logic [3:0]  fpu_id_i = '0;
  logic [31:0] fpu_data_i = '0;
  logic        fpu_we_i = 1'b0;
  logic        x_result_valid_o;
  logic        x_result_ready_i = 1'b0;
  logic [3:0]  x_result_id_o;
  logic [4:0]  x_result_rd_o;
  logic [31:0] x_result_data_o;
  logic        x_result_we_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  fpu_ss_int_wb #(
    .CSR_DEPTH (DEPTH),
    .ID_WIDTH  (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .csr_wb_i         (csr_wb_i),
    .csr_wb_addr_i    (csr_wb_addr_i),
    .csr_wb_id_i      (csr_wb_id_i),
    .csr_rdata_i      (csr_rdata_i),
    .csr_stall_o      (csr_stall_o),
    .fpu_valid_i      (fpu_valid_i),
    .fpu_ready_o      (fpu_ready_o),
    .fpu_rd_i         (fpu_rd_i),
    .fpu_id_i         (fpu_id_i),
    .fpu_data_i       (fpu_data_i),
    .fpu_we_i         (fpu_we_i),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_id_o    (x_result_id_o),
    .x_result_rd_o    (x_result_rd_o),
    .x_result_data_o  (x_result_data_o),
    .x_result_we_o    (x_result_we_o),
    .overflow_o       (overflow_o)
  );

  typedef struct {
    bit [3:0]  id;
    bit [4:0]  rd;
    bit [31:0] data;
    bit        we;
  } ent_t;

  // Reference model state.
  ent_t m_q[$];
  bit   m_valid;
  ent_t m_out;
  bit   m_last_csr;
  bit   m_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_valid    = 1'b0;
    m_out      = '{id: 0, rd: 0, data: 0, we: 0};
    m_last_csr = 1'b0;
    m_ovf      = 1'b0;
  endtask

  // Entered and left at posedge+1; reset spans one clock edge.
  task automatic do_reset();
    rst_i = 1'b1;
    csr_wb_i = 1'b0;
    fpu_valid_i = 1'b0;
    x_result_ready_i = 1'b0;
    #2;
    check_eq("rst_valid", x_result_valid_o, 0);
    check_eq("rst_id", x_result_id_o, 0);
    check_eq("rst_rd", x_result_rd_o, 0);
    check_eq("rst_data", x_result_data_o, 0);
    check_eq("rst_we", x_result_we_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_stall", csr_stall_o, 0);
    check_eq("rst_fready", fpu_ready_o, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  // One clock cycle: drive, compare against model, advance model across the edge.
  task automatic cycle(input bit cwb, input bit [4:0] crd, input bit [3:0] cid,
                       input bit [31:0] cdat, input bit fv, input bit [4:0] frd,
                       input bit [3:0] fid, input bit [31:0] fdat, input bit fwe,
                       input bit rdy);
    bit   can_load, csr_req, csr_wins_tie, exp_fready, take_csr, take_fpu;
    ent_t e;
    csr_wb_i = cwb; csr_wb_addr_i = crd; csr_wb_id_i = cid; csr_rdata_i = cdat;
    fpu_valid_i = fv; fpu_rd_i = frd; fpu_id_i = fid; fpu_data_i = fdat; fpu_we_i = fwe;
    x_result_ready_i = rdy;
    #3;
    can_load     = !m_valid || rdy;
    csr_req      = m_q.size() > 0;
    // Tie-break: full FIFO wins, otherwise whichever source did not win last.
    csr_wins_tie = (m_q.size() == DEPTH) || !m_last_csr;
    exp_fready   = can_load && (!csr_req || !csr_wins_tie);
    check_eq("fpu_ready", fpu_ready_o, exp_fready);
    check_eq("csr_stall", csr_stall_o, m_q.size() >= DEPTH - 1);
    check_eq("valid", x_result_valid_o, m_valid);
    check_eq("overflow", overflow_o, m_ovf);
    if (m_valid) begin
      check_eq("res_id", x_result_id_o, m_out.id);
      check_eq("res_rd", x_result_rd_o, m_out.rd);
      check_eq("res_data", x_result_data_o, m_out.data);
      check_eq("res_we", x_result_we_o, m_out.we);
    end
    take_csr = can_load && csr_req && (!fv || csr_wins_tie);
    take_fpu = can_load && fv && exp_fready;
    if (take_csr) begin
      m_out = m_q.pop_front();
      m_valid = 1'b1;
      m_last_csr = 1'b1;
    end else if (take_fpu) begin
      m_out = '{id: fid, rd: frd, data: fdat, we: fwe};
      m_valid = 1'b1;
      m_last_csr = 1'b0;
    end else if (can_load) begin
      m_valid = 1'b0;
    end
    if (cwb) begin
      if (m_q.size() < DEPTH) begin
        e = '{id: cid, rd: crd, data: cdat, we: (crd != 0)};
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic csr_pulse(input bit [4:0] rd, input bit [3:0] id, input bit [31:0] d,
                           input bit rdy);
    cycle(1, rd, id, d, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Idle CSR pulse: result appears two cycles later, for one cycle.
    csr_pulse(5, 3, 32'hE0, 1);
    check_eq("t1_n1_valid", x_result_valid_o, 0);
    idle(1);
    check_eq("t1_n2_valid", x_result_valid_o, 1);
    check_eq("t1_id", x_result_id_o, 3);
    check_eq("t1_rd", x_result_rd_o, 5);
    check_eq("t1_data", x_result_data_o, 32'hE0);
    check_eq("t1_we", x_result_we_o, 1);
    idle(1);
    check_eq("t1_n3_valid", x_result_valid_o, 0);

    // rd=0 gives we=0.
    csr_pulse(0, 7, 32'h1234, 1);
    idle(1);
    check_eq("t2_valid", x_result_valid_o, 1);
    check_eq("t2_we", x_result_we_o, 0);
    idle(1);

    // FPU accepted when idle shows up one cycle later.
    cycle(0, 0, 0, 0, 1, 9, 4, 32'hF00D, 1, 1);
    check_eq("fpu_lat_valid", x_result_valid_o, 1);
    check_eq("fpu_lat_data", x_result_data_o, 32'hF00D);
    idle(1);

    // Backpressure with CSR pulses and a waiting FPU result.
    csr_pulse(1, 1, 32'hA1, 0);
    check_eq("t3_stall", csr_stall_o, 1);
    csr_pulse(2, 2, 32'hA2, 0);
    cycle(1, 3, 3, 32'hA3, 1, 10, 9, 32'hB1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 10, 9, 32'hB1, 1, 0);
      check_eq("t3_fready", fpu_ready_o, 0);
      check_eq("t3_hold_data", x_result_data_o, 32'hA1);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, i < 2, 10, 9, 32'hB1, 1, 1);

    // FIFO busy plus continuous FPU valid: model enforces alternation.
    for (int i = 0; i < 12; i++)
      cycle(i % 2 == 0, 5'(i + 1), 4'(i), 32'(100 + i), 1, 5'(20 + i), 4'(i + 8),
            32'(200 + i), 1, 1);
    for (int i = 0; i < 4; i++) idle(1);

    // Overflow: pulses with the output stalled.
    for (int i = 0; i < 4; i++) csr_pulse(5'(i + 1), 4'(i), 32'(300 + i), 0);
    check_eq("t5_ovf", overflow_o, 1);
    for (int i = 0; i < 3; i++) idle(0);
    check_eq("t5_ovf_sticky", overflow_o, 1);
    for (int i = 0; i < 5; i++) idle(1);
    check_eq("t5_ovf_after", overflow_o, 1);

    // Reset with buffered entries.
    csr_pulse(1, 1, 32'h11, 0);
    csr_pulse(2, 2, 32'h22, 0);
    csr_pulse(3, 3, 32'h33, 0);
    do_reset();
    for (int i = 0; i < 4; i++) idle(1);
    check_eq("t6_no_stale", x_result_valid_o, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      else cycle($urandom_range(0, 99) < 35, 5'($urandom), 4'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom), 4'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
